// File: rtl/easyaxi_slv_rd_if.sv
// AXI read-channel bundle (AR + R) shared by the read slave and its master.
interface easyaxi_slv_rd_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);

  logic                  axi_ar_valid;
  logic                  axi_ar_ready;
  logic [ID_WIDTH-1:0]   axi_ar_id;
  logic [ADDR_WIDTH-1:0] axi_ar_addr;
  logic [7:0]            axi_ar_len;
  logic [2:0]            axi_ar_size;
  logic [1:0]            axi_ar_burst;

  logic                  axi_r_valid;
  logic                  axi_r_ready;
  logic [ID_WIDTH-1:0]   axi_r_id;
  logic [DATA_WIDTH-1:0] axi_r_data;
  logic [1:0]            axi_r_resp;
  logic                  axi_r_last;

  modport slave (
    input  axi_ar_valid, axi_ar_id, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst,
    input  axi_r_ready,
    output axi_ar_ready,
    output axi_r_valid, axi_r_id, axi_r_data, axi_r_resp, axi_r_last
  );

  modport master (
    output axi_ar_valid, axi_ar_id, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst,
    output axi_r_ready,
    input  axi_ar_ready,
    input  axi_r_valid, axi_r_id, axi_r_data, axi_r_resp, axi_r_last
  );

endinterface

// File: rtl/easyaxi_slv_rd.sv
// Simple AXI read slave: queues AR requests and answers each burst in order after a fixed
// latency, returning the beat address and beat index as read data.
module easyaxi_slv_rd #(
  parameter int unsigned OST_DEPTH  = 16,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  easyaxi_slv_rd_if.slave   axi
);

  localparam int unsigned PtrW    = $clog2(OST_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned EntryW  = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
  localparam int unsigned WaitW   = $clog2(RD_LATENCY + 1);
  localparam int unsigned MaxSize = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  state_e state_q, state_d;

  // Request queue
  logic [EntryW-1:0] mem_q [OST_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              full, empty, push, pop;

  logic [EntryW-1:0]     head;
  logic [ID_WIDTH-1:0]   h_id;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [7:0]            h_len;
  logic [2:0]            h_size;
  logic [1:0]            h_burst;
  logic                  h_err;

  // Working registers for the burst in flight
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nxt;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic [7:0]            beat_q, beat_d;
  logic [WaitW-1:0]      wait_q, wait_d;

  logic [ADDR_WIDTH-1:0] step, wrap_mask;

  logic                  r_valid, r_last;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;

  // Ready depends only on the registered count, so a full queue never passes through.
  assign full  = (cnt_q == CntW'(OST_DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = axi.axi_ar_valid & ~full;

  assign head = mem_q[rd_ptr_q];
  assign {h_id, h_addr, h_len, h_size, h_burst} = head;

  // Reserved burst type, beat wider than the bus, or an illegal wrap length all error out.
  assign h_err = (h_burst == 2'b11) || (h_size > 3'(MaxSize)) ||
                 ((h_burst == BurstWrap) && !(h_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // Queue storage: no reset needed, entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {axi.axi_ar_id, axi.axi_ar_addr, axi.axi_ar_len, axi.axi_ar_size,
                          axi.axi_ar_burst};
    end
  end

  // Queue occupancy next state
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Next beat address for FIXED / INCR / WRAP; errored bursts keep the start address.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    addr_nxt  = addr_q;
    if (!err_q) begin
      case (burst_q)
        BurstIncr: addr_nxt = addr_q + step;
        BurstWrap: addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
        default:   addr_nxt = addr_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!empty) state_d = StWait;
      StWait:  if (wait_q == '0) state_d = StBurst;
      StBurst: if (axi.axi_r_ready && (beat_q == len_q)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: queue pop and the R channel, driven purely from registered state
  always_comb begin
    pop     = 1'b0;
    r_valid = 1'b0;
    r_id    = '0;
    r_data  = '0;
    r_resp  = 2'b00;
    r_last  = 1'b0;
    case (state_q)
      StIdle: pop = !empty;
      StBurst: begin
        r_valid                    = 1'b1;
        r_id                       = id_q;
        r_data[ADDR_WIDTH-1:0]     = addr_q;
        r_data[ADDR_WIDTH +: 8]    = beat_q;
        r_resp                     = err_q ? 2'b10 : 2'b00;
        r_last                     = (beat_q == len_q);
      end
      default: ;
    endcase
  end

  // Working-register next state
  always_comb begin
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          id_d    = h_id;
          addr_d  = h_addr;
          len_d   = h_len;
          size_d  = h_size;
          burst_d = h_burst;
          err_d   = h_err;
          beat_d  = '0;
          wait_d  = WaitW'(RD_LATENCY - 1);
        end
      end
      StWait: if (wait_q != '0) wait_d = wait_q - WaitW'(1);
      StBurst: begin
        if (axi.axi_r_ready) begin
          beat_d = beat_q + 8'd1;
          addr_d = addr_nxt;
        end
      end
      default: ;
    endcase
  end

  // Working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end

  assign axi.axi_ar_ready = ~full;
  assign axi.axi_r_valid  = r_valid;
  assign axi.axi_r_id     = r_id;
  assign axi.axi_r_data   = r_data;
  assign axi.axi_r_resp   = r_resp;
  assign axi.axi_r_last   = r_last;

endmodule

// File: doc/easyaxi_slv_rd.md
EASYAXI_SLV_RD -- requirements
Module: easyaxi_slv_rd

Interface
REQ-001 The block SHALL have parameter OST_DEPTH, default 16, giving the request queue depth (power of two, >=2).
REQ-002 The block SHALL have parameter ID_WIDTH, default 4, giving the AR/R ID width.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 32, giving the address width.
REQ-004 The block SHALL have parameter DATA_WIDTH, default 64, giving the R data width (power of two, >= ADDR_WIDTH+8).
REQ-005 The block SHALL have parameter RD_LATENCY, default 2, giving the wait cycles before the first beat (>=1).
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low: clk  input  1  clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 axi_ar_valid  input  1  read request valid.
REQ-009 axi_ar_ready  output  1  read request accepted.
REQ-010 axi_ar_id  input  ID_WIDTH  request ID.
REQ-011 axi_ar_addr  input  ADDR_WIDTH  start byte address.
REQ-012 axi_ar_len  input  8  beats minus one.
REQ-013 axi_ar_size  input  3  log2 bytes per beat.
REQ-014 axi_ar_burst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-015 axi_r_valid  output  1  read beat valid.
REQ-016 axi_r_ready  input  1  read beat accepted.
REQ-017 axi_r_id, axi_r_data, axi_r_resp, axi_r_last  output  ID_WIDTH / DATA_WIDTH / 2 / 1  beat ID, data, response, last flag.

Function
REQ-018 AR handshake = axi_ar_valid & axi_ar_ready; on handshake id/addr/len/size/burst SHALL be pushed into an OST_DEPTH-entry FIFO.
REQ-019 axi_ar_ready SHALL equal NOT(queue full), evaluated on the count before any same-cycle pop (no full-queue pass-through).
REQ-020 The FSM SHALL have states IDLE, WAIT, BURST; reset state IDLE.
REQ-021 IDLE: if queue non-empty, pop the head into working registers, clear beat counter, load wait counter with RD_LATENCY-1, go WAIT; else stay.
REQ-022 WAIT: decrement counter; when counter==0 go BURST (WAIT lasts exactly RD_LATENCY cycles).
REQ-023 BURST: axi_r_valid=1; on R handshake increment beat counter and update address; on the handshake of beat len go IDLE.
REQ-024 An AR handshake in cycle T into an empty idle block SHALL give first axi_r_valid in cycle T+2+RD_LATENCY.
REQ-025 Responses SHALL be returned in acceptance order, whole bursts, never interleaved.
REQ-026 While axi_r_valid=1 and axi_r_ready=0, all R outputs SHALL hold stable.
REQ-027 axi_r_data[ADDR_WIDTH-1:0] SHALL be the current beat address; axi_r_data[ADDR_WIDTH+7:ADDR_WIDTH] the beat index; remaining bits 0.
REQ-028 axi_r_last SHALL be 1 only on beat index == len; axi_r_id SHALL be the request ID.
REQ-029 FIXED: address constant; INCR: address += 2^size, modulo 2^ADDR_WIDTH.
REQ-030 WRAP: boundary = (len+1)*2^size; next = (addr & ~(boundary-1)) | ((addr+2^size) & (boundary-1)); len other than 1/3/7/15 SHALL be treated as reserved.
REQ-031 axi_r_resp SHALL be 2'b10 (SLVERR) on every beat when burst is reserved or 2^size > DATA_WIDTH/8; address then held fixed; otherwise 2'b00.
REQ-032 Because the head is popped into working registers, OST_DEPTH+1 requests SHALL be accepted before axi_ar_ready drops when R is stalled.

Reset
REQ-033 While rst_n=0: axi_r_valid=0, axi_r_last=0, axi_r_id=0, axi_r_data=0, axi_r_resp=0, queue empty, FSM IDLE, counters 0, axi_ar_ready=1.
REQ-034 Reset asserted mid-burst or mid-WAIT SHALL abort immediately and discard all queued and in-flight requests; no beat follows reset release without a new AR.

Verification
REQ-035 AR id=3 addr=0x100 len=3 size=3 INCR at T, r_ready=1, RD_LATENCY=2 -> beats T+4..T+7, data low 0x100/0x108/0x110/0x118, id 3, resp 0, last only at T+7.
REQ-036 WRAP addr=0x38 len=3 size=3 -> addresses 0x38, 0x20, 0x28, 0x30; FIXED addr=0x40 len=2 -> 0x40 x3.
REQ-037 r_ready=0, AR valid continuously, OST_DEPTH=16 -> exactly 17 accepted then ar_ready=0; release r_ready -> 17 bursts in order, ar_ready=1 after first pop.
REQ-038 r_ready toggled 1/0 every cycle during len=7 burst -> 8 beats, outputs stable in every stalled cycle, no beat lost or duplicated.
REQ-039 burst=11 len=1, then size=7 INCR len=0 (DATA_WIDTH=64) -> resp 2'b10 on all three beats, address constant.
REQ-040 rst_n pulsed low during beat 2 of len=7 with 3 queued -> r_valid=0 asynchronously, ar_ready=1, no further R beats after release.
